credit_switch_allocator: RTL and testbench
==========================================

// Module: credit_switch_allocator
// PURPOSE
//  Next-generation switch allocator for the NoC router. Sits between the input blocks and the crossbar.
//  Replaces on/off flow control with per-(output port, downstream VC) credit counters.
//  Does separable input-first allocation: round-robin over VCs per input, then round-robin over inputs per output.
//  Grants are registered: 1-cycle latency from request to crossbar/input-block select.
// PARAMETERS
//  PORT_NUM      5   number of router ports (in = out)
//  VC_NUM        2   virtual channels per port
//  BUFFER_DEPTH  4   flit slots per downstream VC; reset value and ceiling of each credit counter
//  Derived: PORT_SIZE=$clog2(PORT_NUM), VC_SIZE=$clog2(VC_NUM), CNT_W=$clog2(BUFFER_DEPTH+1)
// PORTS
//  clk              in   1                       clock
//  rst              in   1                       asynchronous, active-high reset
//  switch_request_i in   [PORT_NUM][VC_NUM]      input VC holds a flit wanting the switch
//  out_port_i       in   [PORT_NUM][VC_NUM]xPORT_SIZE  output port requested by each input VC
//  downstream_vc_i  in   [PORT_NUM][VC_NUM]xVC_SIZE    downstream VC allocated to each input VC
//  is_tail_i        in   [PORT_NUM][VC_NUM]      requesting flit is a tail (or head-tail)
//  credit_i         in   [PORT_NUM][VC_NUM]      1-cycle credit return pulse: downstream router, per out port/VC
//  valid_sel_o      out  [PORT_NUM]              input port wins this cycle; pop a flit
//  in_vc_sel_o      out  [PORT_NUM]xVC_SIZE      per input: local VC to read
//  xbar_sel_o       out  [PORT_NUM]xPORT_SIZE    per output: input port driving the crossbar
//  out_vc_o         out  [PORT_NUM]xVC_SIZE      per output: downstream VC id of the outgoing flit
//  valid_flit_o     out  [PORT_NUM]              per output: flit valid toward downstream router
//  credit_err_o     out  1                       sticky: credit returned to a full counter
// BEHAVIOUR
//  Reset (async): all outputs 0; credit_cnt[o][v]=BUFFER_DEPTH; arbiter pointers=0; locks cleared.
//  Eligibility (cycle t): switch_request_i[i][v] && out_port_i[i][v]<PORT_NUM
//   && credit_cnt[out_port_i][downstream_vc_i]!=0.
//   A request with out_port_i>=PORT_NUM is ignored.
//  Stage 1: per input, round-robin over eligible VCs, starting at in_ptr[i]. Gives one candidate (i, v).
//  Stage 2: per output, round-robin over the inputs whose candidate targets it, starting at out_ptr[o].
//  Register at the edge ending cycle t; visible in cycle t+1:
//   valid_sel_o[i]=1, in_vc_sel_o[i]=v, valid_flit_o[o]=1, xbar_sel_o[o]=i, out_vc_o[o]=downstream_vc_i[i][v].
//   Outputs are held only 1 cycle; all valid bits are 0 in cycles with no grant.
//  Pointers: out_ptr[o] moves to (i+1)%PORT_NUM on a grant.
//   in_ptr[i] moves to (v+1)%VC_NUM only when the input's candidate wins stage 2.
//   A losing input keeps its pointer.
//  Credits, per counter, at each edge:
//   -1 on grant of that (o, dvc); +1 on credit_i[o][dvc].
//   Both in the same cycle: count unchanged.
//   +1 while count==BUFFER_DEPTH and no grant: count held, credit_err_o set until rst.
//   Grant never issued at 0, so no underflow.
//  At most one grant per input and per output each cycle.
//  Two VCs of one input targeting different outputs: only one is served per cycle.
//  Reset asserted mid-operation clears everything in the same cycle. Pending grants are dropped, not replayed.
// CONFIGURATION
//  `SA_PACKET_LOCK_EN defined: wormhole output lock.
//   A non-tail grant on output o locks o to (i, v).
//   While o is locked, stage 2 for o accepts only input i.
//   Stage 1 of input i picks v whenever v is eligible and targets o.
//   A tail grant from (i, v) releases the lock at the same edge.
//   Credit stall while locked: o idles and is not reallocated.
//  Not defined: flit-by-flit arbitration; is_tail_i ignored; no lock state synthesized.
// TESTING
//  Reset/idle: rst pulse, no requests -> all outputs 0; credits 4 (BUFFER_DEPTH=4).
//  Single flow: in1 VC0 -> out3 dvc1, held 4 cycles, no credits returned ->
//   grants in cycles 2..5, then stalls; credit_i[3][1] pulse -> one more grant next cycle.
//  Contention: in0 and in2 both -> out4, all VCs requesting ->
//   grants alternate in0, in2, in0... (xbar_sel_o[4] = 0, 2, 0).
//  VC fairness: in1 VC0 and VC1 both -> out2 -> in_vc_sel_o[1] alternates 0, 1, 0.
//  Credit edge: grant and credit_i on same counter in one cycle -> count unchanged;
//   extra credit at 4 -> credit_err_o=1 and stays 1.
//  Lock (`SA_PACKET_LOCK_EN): in0 sends a 3-flit packet to out1 while in2 also requests out1 ->
//   in2 is granted only after in0's tail.
//   Without the macro the flits interleave.

Source files
------------

// File: rtl/credit_switch_allocator.sv
// Credit-based separable input-first switch allocator with registered grants.
// Optional wormhole output locking is enabled by defining SA_PACKET_LOCK_EN.
module credit_switch_allocator #(
  parameter int PORT_NUM     = 5,
  parameter int VC_NUM       = 2,
  parameter int BUFFER_DEPTH = 4,
  localparam int PORT_SIZE = $clog2(PORT_NUM),
  localparam int VC_SIZE   = $clog2(VC_NUM),
  localparam int CNT_W     = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0] switch_request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0] is_tail_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0] credit_i,
  output logic [PORT_NUM-1:0] valid_sel_o,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0] in_vc_sel_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel_o,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0] out_vc_o,
  output logic [PORT_NUM-1:0] valid_flit_o,
  output logic credit_err_o
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_DEPTH);

  logic [CNT_W-1:0] cnt [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0] in_ptr [PORT_NUM];
  logic [VC_SIZE-1:0] in_ptr_nxt [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr [PORT_NUM];
  logic [PORT_SIZE-1:0] out_ptr_nxt [PORT_NUM];
  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic [PORT_NUM-1:0] cand_vld;
  logic [VC_SIZE-1:0] cand_vc [PORT_NUM];
  logic [PORT_SIZE-1:0] cand_port [PORT_NUM];
  logic [PORT_NUM-1:0] gnt;
  logic [PORT_SIZE-1:0] gnt_in [PORT_NUM];
  logic [VC_SIZE-1:0] gnt_dvc [PORT_NUM];
  logic [PORT_NUM-1:0] win;
  logic [PORT_NUM-1:0][VC_NUM-1:0] dec;
`ifdef SA_PACKET_LOCK_EN
  logic [PORT_NUM-1:0] lock_vld;
  logic [PORT_SIZE-1:0] lock_in [PORT_NUM];
  logic [VC_SIZE-1:0] lock_vc [PORT_NUM];
`else
  logic unused_tail;
  assign unused_tail = ^is_tail_i;
`endif

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        elig[i][v] = 1'b0;
        if (switch_request_i[i][v] &&
            int'(out_port_i[i][v]) < PORT_NUM)
          elig[i][v] =
            cnt[out_port_i[i][v]][downstream_vc_i[i][v]] != '0;
      end
    end
  end

  // Stage 1: one candidate VC per input; a held lock overrides round-robin
  always_comb begin
    logic found;
    int s;
    logic [VC_SIZE-1:0] vi;
    found = 1'b0;
    s = 0;
    vi = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      found = 1'b0;
      cand_vc[i] = '0;
`ifdef SA_PACKET_LOCK_EN
      for (int o = 0; o < PORT_NUM; o++)
        if (lock_vld[o] && lock_in[o] == PORT_SIZE'(o * 0 + i) &&
            elig[i][lock_vc[o]] &&
            out_port_i[i][lock_vc[o]] == PORT_SIZE'(o)) begin
          found = 1'b1;
          cand_vc[i] = lock_vc[o];
        end
`endif
      for (int k = 0; k < VC_NUM; k++) begin
        s = int'(in_ptr[i]) + k;
        if (s >= VC_NUM) s = s - VC_NUM;
        vi = VC_SIZE'(s);
        if (!found && elig[i][vi]) begin
          found = 1'b1;
          cand_vc[i] = vi;
        end
      end
      cand_vld[i] = found;
      cand_port[i] = out_port_i[i][cand_vc[i]];
      s = int'(cand_vc[i]) + 1;
      if (s >= VC_NUM) s = 0;
      in_ptr_nxt[i] = VC_SIZE'(s);
    end
  end

  // Stage 2: one winning input per output
  always_comb begin
    logic ok;
    int s;
    logic [PORT_SIZE-1:0] pi;
    ok = 1'b0;
    s = 0;
    pi = '0;
    win = '0;
    dec = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      gnt[o] = 1'b0;
      gnt_in[o] = '0;
      for (int k = 0; k < PORT_NUM; k++) begin
        s = int'(out_ptr[o]) + k;
        if (s >= PORT_NUM) s = s - PORT_NUM;
        pi = PORT_SIZE'(s);
        ok = cand_vld[pi] && cand_port[pi] == PORT_SIZE'(o);
`ifdef SA_PACKET_LOCK_EN
        if (lock_vld[o])
          ok = ok && lock_in[o] == pi && cand_vc[pi] == lock_vc[o];
`endif
        if (!gnt[o] && ok) begin
          gnt[o] = 1'b1;
          gnt_in[o] = pi;
        end
      end
      gnt_dvc[o] = downstream_vc_i[gnt_in[o]][cand_vc[gnt_in[o]]];
      s = int'(gnt_in[o]) + 1;
      if (s >= PORT_NUM) s = 0;
      out_ptr_nxt[o] = PORT_SIZE'(s);
      if (gnt[o]) begin
        win[gnt_in[o]] = 1'b1;
        dec[o][gnt_dvc[o]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_sel_o <= '0;
      in_vc_sel_o <= '0;
      xbar_sel_o <= '0;
      out_vc_o <= '0;
      valid_flit_o <= '0;
      credit_err_o <= 1'b0;
      for (int i = 0; i < PORT_NUM; i++) begin
        in_ptr[i] <= '0;
        out_ptr[i] <= '0;
        for (int v = 0; v < VC_NUM; v++) cnt[i][v] <= FULL;
      end
    end else begin
      valid_sel_o <= win;
      valid_flit_o <= gnt;
      for (int i = 0; i < PORT_NUM; i++) begin
        in_vc_sel_o[i] <= win[i] ? cand_vc[i] : '0;
        if (win[i]) in_ptr[i] <= in_ptr_nxt[i];
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        xbar_sel_o[o] <= gnt[o] ? gnt_in[o] : '0;
        out_vc_o[o] <= gnt[o] ? gnt_dvc[o] : '0;
        if (gnt[o]) out_ptr[o] <= out_ptr_nxt[o];
        for (int v = 0; v < VC_NUM; v++) begin
          if (dec[o][v] && !credit_i[o][v])
            cnt[o][v] <= cnt[o][v] - CNT_W'(1);
          else if (credit_i[o][v] && !dec[o][v]) begin
            if (cnt[o][v] == FULL) credit_err_o <= 1'b1;
            else cnt[o][v] <= cnt[o][v] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef SA_PACKET_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_vld <= '0;
      for (int o = 0; o < PORT_NUM; o++) begin
        lock_in[o] <= '0;
        lock_vc[o] <= '0;
      end
    end else begin
      for (int o = 0; o < PORT_NUM; o++)
        if (gnt[o]) begin
          lock_vld[o] <= !is_tail_i[gnt_in[o]][cand_vc[gnt_in[o]]];
          lock_in[o] <= gnt_in[o];
          lock_vc[o] <= cand_vc[gnt_in[o]];
        end
    end
  end
`endif
endmodule

// File: tb/tb_credit_switch_allocator.sv
// Directed self-checking bench for credit_switch_allocator (5 ports, 2 VCs, depth 4).
module tb_credit_switch_allocator;
  localparam int P = 5;
  localparam int V = 2;
  localparam int PS = 3;
  localparam int VS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [P-1:0][V-1:0] req, tail, credit;
  logic [P-1:0][V-1:0][PS-1:0] oport;
  logic [P-1:0][V-1:0][VS-1:0] dvc;
  logic [P-1:0] valid_sel, valid_flit;
  logic [P-1:0][VS-1:0] in_vc_sel, out_vc;
  logic [P-1:0][PS-1:0] xbar_sel;
  logic credit_err;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  credit_switch_allocator dut (
    .clk(clk),
    .rst(rst),
    .switch_request_i(req),
    .out_port_i(oport),
    .downstream_vc_i(dvc),
    .is_tail_i(tail),
    .credit_i(credit),
    .valid_sel_o(valid_sel),
    .in_vc_sel_o(in_vc_sel),
    .xbar_sel_o(xbar_sel),
    .out_vc_o(out_vc),
    .valid_flit_o(valid_flit),
    .credit_err_o(credit_err)
  );

  task automatic clear_in;
    req = '0;
    tail = '0;
    credit = '0;
    oport = '0;
    dvc = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_in();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_in();
    rst = 1'b1;
    step();
    total++;
    if (valid_sel !== '0) begin
      bad++; $display("FAIL rst_sel got=%b exp=0", valid_sel);
    end
    total++;
    if (valid_flit !== '0) begin
      bad++; $display("FAIL rst_flit got=%b exp=0", valid_flit);
    end
    total++;
    if (xbar_sel !== '0 || in_vc_sel !== '0 || out_vc !== '0) begin
      bad++; $display("FAIL rst_sels got=%h/%h/%h exp=0", xbar_sel, in_vc_sel, out_vc);
    end
    total++;
    if (credit_err !== 1'b0) begin
      bad++; $display("FAIL rst_err got=%b exp=0", credit_err);
    end
    rst = 1'b0;
    req[1][0] = 1'b1; oport[1][0] = 3'd3; dvc[1][0] = 1'b1;
    step();
    total++;
    if (valid_sel !== 5'b00010) begin
      bad++; $display("FAIL pre_async_sel got=%b exp=00010", valid_sel);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (valid_sel !== '0 || valid_flit !== '0) begin
      bad++; $display("FAIL async_rst got=%b/%b exp=0/0", valid_sel, valid_flit);
    end
    step();
    total++;
    if (valid_flit !== '0) begin
      bad++; $display("FAIL rst_hold got=%b exp=0", valid_flit);
    end
    rst = 1'b0;
    clear_in();
    step();
    total++;
    if (valid_flit !== '0) begin
      bad++; $display("FAIL idle got=%b exp=0", valid_flit);
    end
  endtask

  task automatic test_single_flow;
    do_reset();
    req[1][0] = 1'b1; oport[1][0] = 3'd3; dvc[1][0] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      total++;
      if (valid_sel !== 5'b00010) begin
        bad++; $display("FAIL flow_sel%0d got=%b exp=00010", n, valid_sel);
      end
      total++;
      if (valid_flit !== 5'b01000) begin
        bad++; $display("FAIL flow_flit%0d got=%b exp=01000", n, valid_flit);
      end
      total++;
      if (xbar_sel[3] !== 3'd1 || out_vc[3] !== 1'b1 || in_vc_sel[1] !== 1'b0) begin
        bad++; $display("FAIL flow_sel_ids%0d got=%0d/%0d/%0d exp=1/1/0", n, xbar_sel[3], out_vc[3], in_vc_sel[1]);
      end
    end
    for (int n = 0; n < 2; n++) begin
      step();
      total++;
      if (valid_flit !== '0) begin
        bad++; $display("FAIL flow_stall%0d got=%b exp=0", n, valid_flit);
      end
    end
    credit[3][1] = 1'b1;
    step();
    credit = '0;
    total++;
    if (valid_flit !== '0) begin
      bad++; $display("FAIL flow_cr_edge got=%b exp=0", valid_flit);
    end
    step();
    total++;
    if (valid_flit !== 5'b01000) begin
      bad++; $display("FAIL flow_after_cr got=%b exp=01000", valid_flit);
    end
    step();
    total++;
    if (valid_flit !== '0) begin
      bad++; $display("FAIL flow_restall got=%b exp=0", valid_flit);
    end
    clear_in();
  endtask

  task automatic test_contention;
    int exp_in [4] = '{0, 2, 0, 2};
    logic exp_vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [P-1:0] exp_sel;
    do_reset();
    req[0] = 2'b11; req[2] = 2'b11;
    oport[0][0] = 3'd4; oport[0][1] = 3'd4;
    oport[2][0] = 3'd4; oport[2][1] = 3'd4;
    dvc[0][1] = 1'b1; dvc[2][1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      exp_sel = '0;
      exp_sel[exp_in[c]] = 1'b1;
      total++;
      if (xbar_sel[4] !== PS'(exp_in[c]) || valid_flit !== 5'b10000) begin
        bad++; $display("FAIL cont_xbar%0d got=%0d/%b exp=%0d/10000", c, xbar_sel[4], valid_flit, exp_in[c]);
      end
      total++;
      if (valid_sel !== exp_sel) begin
        bad++; $display("FAIL cont_sel%0d got=%b exp=%b", c, valid_sel, exp_sel);
      end
      total++;
      if (in_vc_sel[exp_in[c]] !== exp_vc[c] || out_vc[4] !== exp_vc[c]) begin
        bad++; $display("FAIL cont_vc%0d got=%b/%b exp=%b", c, in_vc_sel[exp_in[c]], out_vc[4], exp_vc[c]);
      end
    end
    clear_in();
  endtask

  task automatic test_vc_fairness;
    logic exp_vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    req[1] = 2'b11;
    oport[1][0] = 3'd2; oport[1][1] = 3'd2;
    dvc[1][1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (in_vc_sel[1] !== exp_vc[c] || out_vc[2] !== exp_vc[c]) begin
        bad++; $display("FAIL vcfair%0d got=%b/%b exp=%b", c, in_vc_sel[1], out_vc[2], exp_vc[c]);
      end
      total++;
      if (valid_sel !== 5'b00010 || valid_flit !== 5'b00100 || xbar_sel[2] !== 3'd1) begin
        bad++; $display("FAIL vcfair_sel%0d got=%b/%b/%0d exp=00010/00100/1", c, valid_sel, valid_flit, xbar_sel[2]);
      end
    end
    clear_in();
  endtask

  task automatic test_parallel;
    do_reset();
    req[3] = 2'b11; oport[3][0] = 3'd0; oport[3][1] = 3'd1;
    req[4][0] = 1'b1; oport[4][0] = 3'd2;
    req[2][0] = 1'b1; oport[2][0] = 3'd7;
    step();
    total++;
    if (valid_flit !== 5'b00101 || valid_sel !== 5'b11000) begin
      bad++; $display("FAIL par0 got=%b/%b exp=00101/11000", valid_flit, valid_sel);
    end
    total++;
    if (xbar_sel[0] !== 3'd3 || xbar_sel[2] !== 3'd4) begin
      bad++; $display("FAIL par0_xbar got=%0d/%0d exp=3/4", xbar_sel[0], xbar_sel[2]);
    end
    step();
    total++;
    if (valid_flit !== 5'b00110 || valid_sel !== 5'b11000) begin
      bad++; $display("FAIL par1 got=%b/%b exp=00110/11000", valid_flit, valid_sel);
    end
    total++;
    if (xbar_sel[1] !== 3'd3 || in_vc_sel[3] !== 1'b1) begin
      bad++; $display("FAIL par1_xbar got=%0d/%b exp=3/1", xbar_sel[1], in_vc_sel[3]);
    end
    clear_in();
  endtask

  task automatic test_credit_edge;
    do_reset();
    req[0][0] = 1'b1; oport[0][0] = 3'd0; dvc[0][0] = 1'b0;
    credit[0][0] = 1'b1;
    step();
    credit = '0;
    total++;
    if (valid_flit !== 5'b00001 || credit_err !== 1'b0) begin
      bad++; $display("FAIL cedge_first got=%b/%b exp=00001/0", valid_flit, credit_err);
    end
    for (int n = 0; n < 4; n++) begin
      step();
      total++;
      if (valid_flit !== 5'b00001) begin
        bad++; $display("FAIL cedge_run%0d got=%b exp=00001", n, valid_flit);
      end
    end
    step();
    req = '0;
    total++;
    if (valid_flit !== '0) begin
      bad++; $display("FAIL cedge_empty got=%b exp=0", valid_flit);
    end
    credit[0][0] = 1'b1;
    for (int n = 0; n < 4; n++) step();
    total++;
    if (credit_err !== 1'b0) begin
      bad++; $display("FAIL cedge_refill_err got=%b exp=0", credit_err);
    end
    step();
    credit = '0;
    total++;
    if (credit_err !== 1'b1) begin
      bad++; $display("FAIL cedge_overflow got=%b exp=1", credit_err);
    end
    for (int n = 0; n < 3; n++) step();
    total++;
    if (credit_err !== 1'b1) begin
      bad++; $display("FAIL cedge_sticky got=%b exp=1", credit_err);
    end
    clear_in();
  endtask

  task automatic test_lock;
`ifdef SA_PACKET_LOCK_EN
    int exp_in [4] = '{0, 0, 0, 2};
`else
    int exp_in [4] = '{0, 2, 0, 2};
`endif
    int n0;
    n0 = 0;
    do_reset();
    req[0][0] = 1'b1; oport[0][0] = 3'd1; dvc[0][0] = 1'b0;
    req[2][0] = 1'b1; oport[2][0] = 3'd1; dvc[2][0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (xbar_sel[1] !== PS'(exp_in[c]) || valid_flit[1] !== 1'b1) begin
        bad++; $display("FAIL lock%0d got=%0d/%b exp=%0d/1", c, xbar_sel[1], valid_flit[1], exp_in[c]);
      end
      if (valid_sel[0]) n0++;
      tail[0][0] = (n0 == 2);
      if (n0 == 3) req[0][0] = 1'b0;
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single_flow();
    test_contention();
    test_vc_fairness();
    test_parallel();
    test_credit_edge();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
